// File: rtl/axi_vga_pkg.sv
// Shared types and defaults for the VGA framebuffer fetch sequencer.
package axi_vga_pkg;

   // Sequencer states: IDLE (display off), OFF (enable-low settle window),
   // RUN (fetching), DRAIN (waiting for in-flight bursts to retire).
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_OFF   = 2'd3
   } frame_ctrl_state_e;

   // Configuration handed to the fetch engine.
   typedef struct packed {
      logic [63:0] addr;
      logic [31:0] size;
      logic [7:0]  burst_len;
   } vga_cfg_t;

   localparam int unsigned MinOffCyclesDefault = 4;

endpackage

// File: rtl/vga_burst_tracker.sv
// Counts AXI read bursts in flight: +1 per AR handshake, -1 per final R beat.
// The count saturates at MaxOutstanding and at 0.
module vga_burst_tracker #(
   parameter  int unsigned MaxOutstanding = 4,
   localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            inc_i,
   input  logic            dec_i,
   input  logic            clear_i,
   output logic            idle_o,
   output logic [CntW-1:0] count_o
);

   localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

   logic [CntW-1:0] count_q;

   // Outstanding-burst counter; simultaneous inc and dec cancel out.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         count_q <= '0;
      end else if (inc_i && !dec_i && (count_q != CntMax)) begin
         count_q <= count_q + CntW'(1);
      end else if (dec_i && !inc_i && (count_q != '0)) begin
         count_q <= count_q - CntW'(1);
      end
   end

   assign idle_o  = (count_q == '0);
   assign count_o = count_q;

   // A final R beat with nothing outstanding means the monitor inputs are broken.
   a_no_count_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(dec_i && !inc_i && (count_q == '0)));

endmodule

// File: rtl/axi_vga_frame_ctrl.sv
// Frame sequencer for the VGA fetch engine: owns the fetch configuration,
// performs vsync-aligned tear-free buffer swaps after draining in-flight
// bursts, counts frames and raises a shared interrupt pulse.
// Optional underflow detection is built when AXI_VGA_FRAME_CTRL_UNDERFLOW_EN
// is defined; otherwise underflow_o is tied low.
module axi_vga_frame_ctrl
   import axi_vga_pkg::*;
#(
   parameter int unsigned AXIStrbWidth   = 8,
   parameter int unsigned MaxOutstanding = 4,
   parameter int unsigned MinOffCycles   = MinOffCyclesDefault
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cfg_enable_i,
   input  logic [63:0] cfg_next_addr_i,
   input  logic        cfg_swap_req_i,
   input  logic [31:0] cfg_frame_size_i,
   input  logic [7:0]  cfg_burst_len_i,
   input  logic        underflow_clr_i,
   input  logic        vsync_i,
   input  logic        de_i,
   input  logic        mon_ar_hs_i,
   input  logic        mon_r_last_hs_i,
   input  logic        mon_px_hs_i,
   input  logic        mon_px_ready_i,
   output logic        fetch_enable_o,
   output logic [63:0] fetch_start_addr_o,
   output logic [31:0] fetch_frame_size_o,
   output logic [7:0]  fetch_burst_len_o,
   output logic [63:0] cur_addr_o,
   output logic        swap_pending_o,
   output logic [31:0] frame_cnt_o,
   output logic        underflow_o,
   output logic        irq_o
);

   localparam int unsigned     BeatShift = $clog2(AXIStrbWidth);
   localparam int unsigned     OffW      = $clog2(MinOffCycles + 1);
   localparam logic [OffW-1:0] OffLast   = OffW'(MinOffCycles - 1);
   localparam int unsigned     TrkW      = $clog2(MaxOutstanding + 1);

   frame_ctrl_state_e state_q, state_d;
   vga_cfg_t          cur_cfg_q;
   logic [63:0]       pend_addr_q;
   logic              pending_q;
   logic              fetch_enable_q;
   logic              drain_dis_q;
   logic [OffW-1:0]   off_cnt_q;
   logic [31:0]       beat_cnt_q;
   logic [31:0]       frame_cnt_q;
   logic [31:0]       beats_per_frame;
   logic              irq_q;

   logic              latch_cfg;
   logic              apply_swap;
   logic              enter_off;
   logic              frame_done;
   logic              uf_rise;
   logic              trk_idle;
   logic [TrkW-1:0]   trk_count;

   // The tracker is cleared in IDLE, where the fetch engine is fully quiesced.
   vga_burst_tracker #(
      .MaxOutstanding (MaxOutstanding)
   ) u_tracker (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (mon_ar_hs_i),
      .dec_i   (mon_r_last_hs_i),
      .clear_i (state_q == ST_IDLE),
      .idle_o  (trk_idle),
      .count_o (trk_count)
   );

   a_idle_matches_count : assert property (@(posedge clk_i) disable iff (rst_i)
      trk_idle == (trk_count == '0));

   // Next-state logic; a falling enable always takes priority over a swap.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      latch_cfg  = 1'b0;
      apply_swap = 1'b0;
      enter_off  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cfg_enable_i) begin
               latch_cfg = 1'b1;
               enter_off = 1'b1;
               state_d   = ST_OFF;
            end
         end
         ST_OFF: begin
            if (!cfg_enable_i) begin
               state_d = ST_DRAIN;
            end else if (off_cnt_q == OffLast) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!cfg_enable_i || (vsync_i && pending_q)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (trk_idle) begin
               if (drain_dis_q || !cfg_enable_i) begin
                  state_d = ST_IDLE;
               end else begin
                  apply_swap = 1'b1;
                  enter_off  = 1'b1;
                  state_d    = ST_OFF;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register, registered fetch enable and the disable-drain marker.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= ST_IDLE;
         fetch_enable_q <= 1'b0;
         drain_dis_q    <= 1'b0;
         off_cnt_q      <= '0;
      end else begin
         state_q        <= state_d;
         fetch_enable_q <= (state_d == ST_RUN);
         drain_dis_q    <= (state_d == ST_DRAIN) && (drain_dis_q || !cfg_enable_i);
         off_cnt_q      <= ((state_q == ST_OFF) && (state_d == ST_OFF)) ?
                           off_cnt_q + OffW'(1) : '0;
      end
   end

   // Current configuration and pending swap; a request in the apply cycle stays pending.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cur_cfg_q   <= '0;
         pend_addr_q <= '0;
         pending_q   <= 1'b0;
      end else begin
         if (latch_cfg) begin
            cur_cfg_q.addr      <= cfg_next_addr_i;
            cur_cfg_q.size      <= cfg_frame_size_i;
            cur_cfg_q.burst_len <= cfg_burst_len_i;
         end else if (apply_swap) begin
            cur_cfg_q.addr <= pend_addr_q;
         end
         if (cfg_swap_req_i) begin
            pend_addr_q <= cfg_next_addr_i;
            pending_q   <= 1'b1;
         end else if (apply_swap) begin
            pending_q <= 1'b0;
         end
      end
   end

   assign beats_per_frame = cur_cfg_q.size >> BeatShift;
   assign frame_done      = mon_px_hs_i && !enter_off &&
                            ((beat_cnt_q + 32'd1) == beats_per_frame);

   // Pixel beat counter and completed-frame counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         beat_cnt_q  <= '0;
         frame_cnt_q <= '0;
      end else begin
         if (enter_off || frame_done) begin
            beat_cnt_q <= '0;
         end else if (mon_px_hs_i) begin
            beat_cnt_q <= beat_cnt_q + 32'd1;
         end
         if (frame_done) begin
            frame_cnt_q <= frame_cnt_q + 32'd1;
         end
      end
   end

`ifdef AXI_VGA_FRAME_CTRL_UNDERFLOW_EN
   logic uf_cond, uf_cond_q, uf_q;

   assign uf_cond = de_i && mon_px_ready_i && !mon_px_hs_i && (state_q == ST_RUN);
   assign uf_rise = uf_cond && !uf_cond_q;

   // Sticky underflow flag; a new rising edge beats a simultaneous clear.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         uf_cond_q <= 1'b0;
         uf_q      <= 1'b0;
      end else begin
         uf_cond_q <= uf_cond;
         if (uf_rise) begin
            uf_q <= 1'b1;
         end else if (underflow_clr_i) begin
            uf_q <= 1'b0;
         end
      end
   end

   assign underflow_o = uf_q;
`else
   logic unused_uf;

   assign unused_uf   = ^{de_i, mon_px_ready_i, underflow_clr_i};
   assign uf_rise     = 1'b0;
   assign underflow_o = 1'b0;
`endif

   // One shared interrupt pulse for frame done, swap done and underflow onset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= frame_done || apply_swap || uf_rise;
      end
   end

   assign fetch_enable_o     = fetch_enable_q;
   assign fetch_start_addr_o = cur_cfg_q.addr;
   assign fetch_frame_size_o = cur_cfg_q.size;
   assign fetch_burst_len_o  = cur_cfg_q.burst_len;
   assign cur_addr_o         = cur_cfg_q.addr;
   assign swap_pending_o     = pending_q;
   assign frame_cnt_o        = frame_cnt_q;
   assign irq_o              = irq_q;

endmodule

// File: tb/tb_axi_vga_frame_ctrl.sv
// Directed bench for axi_vga_frame_ctrl: a vector table covers start-up,
// swaps, vsync filtering and disable; hand sequences cover frame counting,
// tracker balance, underflow and reset during DRAIN.
module tb_axi_vga_frame_ctrl;

   localparam logic [63:0] A0 = 64'h8000_0000;
   localparam logic [63:0] A1 = 64'h8010_0000;
   localparam logic [63:0] A2 = 64'h8020_0000;
   localparam logic [63:0] A3 = 64'h8030_0000;
   localparam logic [63:0] A4 = 64'h8040_0000;
   localparam logic [63:0] A5 = 64'h8050_0000;
   localparam logic [63:0] A6 = 64'h8060_0000;
   localparam logic [63:0] A7 = 64'h8070_0000;
   localparam logic [63:0] A8 = 64'h8080_0000;
   localparam logic [63:0] A9 = 64'h8090_0000;
   localparam logic [63:0] Z  = 64'h0;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cfg_enable_i;
   logic [63:0] cfg_next_addr_i;
   logic        cfg_swap_req_i;
   logic [31:0] cfg_frame_size_i;
   logic [7:0]  cfg_burst_len_i;
   logic        underflow_clr_i;
   logic        vsync_i;
   logic        de_i;
   logic        mon_ar_hs_i;
   logic        mon_r_last_hs_i;
   logic        mon_px_hs_i;
   logic        mon_px_ready_i;
   logic        fetch_enable_o;
   logic [63:0] fetch_start_addr_o;
   logic [31:0] fetch_frame_size_o;
   logic [7:0]  fetch_burst_len_o;
   logic [63:0] cur_addr_o;
   logic        swap_pending_o;
   logic [31:0] frame_cnt_o;
   logic        underflow_o;
   logic        irq_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   axi_vga_frame_ctrl #(
      .AXIStrbWidth   (8),
      .MaxOutstanding (4),
      .MinOffCycles   (4)
   ) dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .cfg_enable_i       (cfg_enable_i),
      .cfg_next_addr_i    (cfg_next_addr_i),
      .cfg_swap_req_i     (cfg_swap_req_i),
      .cfg_frame_size_i   (cfg_frame_size_i),
      .cfg_burst_len_i    (cfg_burst_len_i),
      .underflow_clr_i    (underflow_clr_i),
      .vsync_i            (vsync_i),
      .de_i               (de_i),
      .mon_ar_hs_i        (mon_ar_hs_i),
      .mon_r_last_hs_i    (mon_r_last_hs_i),
      .mon_px_hs_i        (mon_px_hs_i),
      .mon_px_ready_i     (mon_px_ready_i),
      .fetch_enable_o     (fetch_enable_o),
      .fetch_start_addr_o (fetch_start_addr_o),
      .fetch_frame_size_o (fetch_frame_size_o),
      .fetch_burst_len_o  (fetch_burst_len_o),
      .cur_addr_o         (cur_addr_o),
      .swap_pending_o     (swap_pending_o),
      .frame_cnt_o        (frame_cnt_o),
      .underflow_o        (underflow_o),
      .irq_o              (irq_o)
   );

   typedef struct {
      logic        en;
      logic        swap;
      logic [63:0] addr;
      logic        vsync;
      logic        ar;
      logic        rl;
      logic        fen;
      logic [63:0] cur;
      logic        pend;
      logic        irq;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic en, input logic swap, input logic [63:0] addr,
                               input logic vsync, input logic ar, input logic rl,
                               input logic fen, input logic [63:0] cur,
                               input logic pend, input logic irq);
      vec_t v;
      v.en = en; v.swap = swap; v.addr = addr; v.vsync = vsync; v.ar = ar; v.rl = rl;
      v.fen = fen; v.cur = cur; v.pend = pend; v.irq = irq;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock: inputs already set, outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clr_in();
      cfg_swap_req_i  = 1'b0;
      vsync_i         = 1'b0;
      mon_ar_hs_i     = 1'b0;
      mon_r_last_hs_i = 1'b0;
      mon_px_hs_i     = 1'b0;
      de_i            = 1'b0;
      mon_px_ready_i  = 1'b0;
      underflow_clr_i = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int irq_seen;
      int irq_at;
      logic exp_uf;

      rst_i            = 1'b1;
      cfg_enable_i     = 1'b0;
      cfg_next_addr_i  = '0;
      cfg_frame_size_i = 32'h400;
      cfg_burst_len_i  = 8'd15;
      clr_in();
      step();
      step();

      check("rst.fetch_enable", fetch_enable_o, 0);
      check("rst.start_addr", fetch_start_addr_o, 0);
      check("rst.frame_size", fetch_frame_size_o, 0);
      check("rst.burst_len", fetch_burst_len_o, 0);
      check("rst.swap_pending", swap_pending_o, 0);
      check("rst.frame_cnt", frame_cnt_o, 0);
      check("rst.underflow", underflow_o, 0);
      check("rst.irq", irq_o, 0);
      rst_i = 1'b0;

      //                 en swp addr vs ar rl | fen cur pend irq
      vecs.push_back(mk(1, 0, A0, 0, 0, 0,   0, A0, 0, 0)); // IDLE->OFF latch A0
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   0, A0, 0, 0));
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   0, A0, 0, 0));
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   0, A0, 0, 0));
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   1, A0, 0, 0)); // OFF done -> RUN
      vecs.push_back(mk(1, 1, A1, 0, 0, 0,   1, A0, 1, 0)); // request A1
      vecs.push_back(mk(1, 0, Z,  0, 1, 0,   1, A0, 1, 0));
      vecs.push_back(mk(1, 0, Z,  0, 1, 0,   1, A0, 1, 0)); // 2 outstanding
      vecs.push_back(mk(1, 0, Z,  1, 0, 0,   0, A0, 1, 0)); // vsync -> DRAIN
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   0, A0, 1, 0));
      vecs.push_back(mk(1, 0, Z,  0, 0, 1,   0, A0, 1, 0));
      vecs.push_back(mk(1, 0, Z,  0, 0, 1,   0, A0, 1, 0));
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   0, A1, 0, 1)); // drained: swap A1
      vecs.push_back(mk(1, 1, A2, 0, 0, 0,   0, A1, 1, 0)); // request in OFF
      vecs.push_back(mk(1, 0, Z,  1, 0, 0,   0, A1, 1, 0)); // vsync in OFF ignored
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   0, A1, 1, 0));
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   1, A1, 1, 0));
      vecs.push_back(mk(1, 0, Z,  1, 0, 0,   0, A1, 1, 0)); // vsync in RUN
      vecs.push_back(mk(1, 1, A3, 0, 0, 0,   0, A2, 1, 1)); // apply A2, A3 kept
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   0, A2, 1, 0));
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   0, A2, 1, 0));
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   0, A2, 1, 0));
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   1, A2, 1, 0));
      vecs.push_back(mk(1, 0, Z,  1, 0, 0,   0, A2, 1, 0));
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   0, A3, 0, 1)); // apply A3
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   0, A3, 0, 0));
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   0, A3, 0, 0));
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   0, A3, 0, 0));
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   1, A3, 0, 0));
      vecs.push_back(mk(1, 1, A4, 0, 0, 0,   1, A3, 1, 0)); // A then B
      vecs.push_back(mk(1, 1, A5, 0, 0, 0,   1, A3, 1, 0));
      vecs.push_back(mk(1, 0, Z,  1, 0, 0,   0, A3, 1, 0));
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   0, A5, 0, 1)); // only B applied
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   0, A5, 0, 0)); // single irq
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   0, A5, 0, 0));
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   0, A5, 0, 0));
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   1, A5, 0, 0));
      vecs.push_back(mk(1, 1, A6, 0, 0, 0,   1, A5, 1, 0));
      vecs.push_back(mk(0, 0, Z,  1, 0, 0,   0, A5, 1, 0)); // disable + vsync
      vecs.push_back(mk(0, 0, Z,  0, 0, 0,   0, A5, 1, 0)); // drained -> IDLE
      vecs.push_back(mk(0, 0, Z,  0, 0, 0,   0, A5, 1, 0));
      vecs.push_back(mk(1, 0, A7, 0, 0, 0,   0, A7, 1, 0)); // re-enable at A7
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   0, A7, 1, 0));
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   0, A7, 1, 0));
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   0, A7, 1, 0));
      vecs.push_back(mk(1, 0, Z,  0, 0, 0,   1, A7, 1, 0));

      foreach (vecs[i]) begin
         cfg_enable_i    = vecs[i].en;
         cfg_swap_req_i  = vecs[i].swap;
         cfg_next_addr_i = vecs[i].addr;
         vsync_i         = vecs[i].vsync;
         mon_ar_hs_i     = vecs[i].ar;
         mon_r_last_hs_i = vecs[i].rl;
         step();
         check($sformatf("v%0d.fetch_enable", i), fetch_enable_o, vecs[i].fen);
         check($sformatf("v%0d.cur_addr", i), cur_addr_o, vecs[i].cur);
         check($sformatf("v%0d.swap_pending", i), swap_pending_o, vecs[i].pend);
         check($sformatf("v%0d.irq", i), irq_o, vecs[i].irq);
      end
      clr_in();
      check("cfg.start_addr", fetch_start_addr_o, A7);
      check("cfg.frame_size", fetch_frame_size_o, 32'h400);
      check("cfg.burst_len", fetch_burst_len_o, 8'd15);

      // 0x400 bytes / 8 bytes per beat = 128 beats per frame.
      irq_seen = 0;
      irq_at   = -1;
      for (int i = 0; i < 128; i++) begin
         mon_px_hs_i    = 1'b1;
         de_i           = 1'b1;
         mon_px_ready_i = 1'b1;
         step();
         if (irq_o) begin
            irq_seen++;
            irq_at = i;
         end
      end
      clr_in();
      check("frame.irq_count", irq_seen, 1);
      check("frame.irq_at_beat", irq_at, 127);
      check("frame.frame_cnt", frame_cnt_o, 1);
      step();
      check("frame.irq_after", irq_o, 0);
      check("frame.frame_cnt_hold", frame_cnt_o, 1);

      // One burst outstanding, then ten balanced ar/r_last cycles.
      mon_ar_hs_i = 1'b1;
      step();
      for (int i = 0; i < 10; i++) begin
         mon_ar_hs_i     = 1'b1;
         mon_r_last_hs_i = 1'b1;
         step();
      end
      clr_in();
      cfg_swap_req_i  = 1'b1;
      cfg_next_addr_i = A8;
      step();
      clr_in();
      vsync_i = 1'b1;
      step();
      clr_in();
      check("trk.drain_enable", fetch_enable_o, 0);
      step();
      check("trk.still_pending", swap_pending_o, 1);
      check("trk.addr_held", cur_addr_o, A7);
      mon_r_last_hs_i = 1'b1;
      step();
      clr_in();
      check("trk.pending_at_last", swap_pending_o, 1);
      step();
      check("trk.cur_addr", cur_addr_o, A8);
      check("trk.pending_clear", swap_pending_o, 0);
      check("trk.irq", irq_o, 1);
      for (int i = 0; i < 3; i++) step();
      check("trk.off_low", fetch_enable_o, 0);
      step();
      check("trk.reenable", fetch_enable_o, 1);

      // Underflow: pixel wanted and ready but no handshake for three cycles.
`ifdef AXI_VGA_FRAME_CTRL_UNDERFLOW_EN
      exp_uf = 1'b1;
`else
      exp_uf = 1'b0;
`endif
      irq_seen = 0;
      for (int i = 0; i < 3; i++) begin
         de_i           = 1'b1;
         mon_px_ready_i = 1'b1;
         step();
         if (irq_o) irq_seen++;
      end
      check("uf.flag", underflow_o, exp_uf);
      check("uf.irq_count", irq_seen, exp_uf ? 1 : 0);
      clr_in();
      underflow_clr_i = 1'b1;
      step();
      check("uf.cleared", underflow_o, 0);
      de_i           = 1'b1;
      mon_px_ready_i = 1'b1;
      step();
      check("uf.set_beats_clear", underflow_o, exp_uf);
      de_i           = 1'b0;
      mon_px_ready_i = 1'b0;
      step();
      check("uf.cleared_again", underflow_o, 0);
      clr_in();

      // Reset while draining returns straight to IDLE.
      cfg_swap_req_i  = 1'b1;
      cfg_next_addr_i = A9;
      step();
      clr_in();
      mon_ar_hs_i = 1'b1;
      step();
      clr_in();
      vsync_i = 1'b1;
      step();
      clr_in();
      check("rstdrain.in_drain", fetch_enable_o, 0);
      rst_i = 1'b1;
      step();
      check("rstdrain.enable", fetch_enable_o, 0);
      check("rstdrain.cur_addr", cur_addr_o, 0);
      check("rstdrain.pending", swap_pending_o, 0);
      check("rstdrain.frame_cnt", frame_cnt_o, 0);
      rst_i        = 1'b0;
      cfg_enable_i = 1'b0;
      step();
      check("rstdrain.idle", fetch_enable_o, 0);
      cfg_enable_i    = 1'b1;
      cfg_next_addr_i = A0;
      step();
      check("rstdrain.relatch", cur_addr_o, A0);
      for (int i = 0; i < 3; i++) step();
      check("rstdrain.off_low", fetch_enable_o, 0);
      step();
      check("rstdrain.run", fetch_enable_o, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
